// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: receiver state encoding, nominal line timing
// and the 24-bit GRB pixel word used by both the transmitter and receiver.
package ws2812b_pkg;

   typedef enum logic [1:0] {
      WAIT_RESET = 2'd0,
      IDLE_LOW   = 2'd1,
      MEAS_HIGH  = 2'd2,
      MEAS_LOW   = 2'd3
   } rxState_t;

   localparam int T0H_NS     = 400;
   localparam int T1H_NS     = 800;
   localparam int T0L_NS     = 850;
   localparam int T1L_NS     = 450;
   localparam int T_RESET_NS = 50000;

   localparam int PIXEL_W = 24;
   localparam int CNT_W   = 16;

   typedef logic [PIXEL_W-1:0] pixel_t;

   // Converts a duration in ns to whole clock cycles (truncating).
   function automatic logic [CNT_W-1:0] nsToCnt(input int ns, input int clkNs);
      return CNT_W'(ns / clkNs);
   endfunction

endpackage

// File: rtl/ws2812b_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus rise/fall
// detection against the previous synchronized sample.
module ws2812b_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dinS,
   output logic rise,
   output logic fall
);

   logic meta;
   logic syncd;
   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta  <= 1'b0;
         syncd <= 1'b0;
         prev  <= 1'b0;
      end else begin
         meta  <= din;
         syncd <= meta;
         prev  <= syncd;
      end
   end

   assign dinS = syncd;
   assign rise = syncd & ~prev;
   assign fall = ~syncd & prev;

endmodule

// File: rtl/ws2812b_rx_decoder.sv
// WS2812B serial receiver: measures high/low pulse widths, assembles GRB pixels
// and flags frame ends. Optional chain pass-through via WS2812B_RX_PASSTHRU_EN.
module ws2812b_rx_decoder
   import ws2812b_pkg::*;
#(
   parameter int CLK_PERIOD_NS = 10,
   parameter int BIT_THRESH_NS = 600,
   parameter int MIN_HIGH_NS   = 200,
   parameter int MAX_HIGH_NS   = 1200,
   parameter int RESET_NS      = T_RESET_NS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        DIN,
   output logic        pixel_valid,
   output logic [23:0] pixel_data,
   output logic [15:0] pixel_index,
   output logic        frame_done,
   output logic        pulse_err,
   output logic        DOUT
);

   localparam logic [CNT_W-1:0] CNT_BIT_THRESH = nsToCnt(BIT_THRESH_NS, CLK_PERIOD_NS);
   localparam logic [CNT_W-1:0] CNT_MIN_HIGH   = nsToCnt(MIN_HIGH_NS, CLK_PERIOD_NS);
   localparam logic [CNT_W-1:0] CNT_MAX_HIGH   = nsToCnt(MAX_HIGH_NS, CLK_PERIOD_NS);
   localparam logic [CNT_W-1:0] CNT_RESET      = nsToCnt(RESET_NS, CLK_PERIOD_NS);

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic dinS;
   logic dinRise;
   logic dinFall;

   ws2812b_sync uSync (
      .clk   (clk),
      .reset (reset),
      .din   (DIN),
      .dinS  (dinS),
      .rise  (dinRise),
      .fall  (dinFall)
   );

   rxState_t         state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext, cntInc;
   logic [4:0]       bitCnt, bitCntNext;
   pixel_t           shiftReg, shiftNext;
   logic [15:0]      pixCnt, pixCntNext;
   logic             frameActive, frameActiveNext;
   logic             bitVal;
   logic             pvNext, fdNext, peNext;
   pixel_t           dataNext;
   logic [15:0]      idxNext;

   always_comb begin
      stateNext       = state;
      cntNext         = cnt;
      bitCntNext      = bitCnt;
      shiftNext       = shiftReg;
      pixCntNext      = pixCnt;
      frameActiveNext = frameActive;
      pvNext          = 1'b0;
      fdNext          = 1'b0;
      peNext          = 1'b0;
      dataNext        = pixel_data;
      idxNext         = pixel_index;
      cntInc          = satInc(cnt);
      bitVal          = (cnt >= CNT_BIT_THRESH);

      case (state)
         WAIT_RESET: begin
            if (dinS) begin
               cntNext = '0;
            end else if (cntInc >= CNT_RESET) begin
               stateNext       = IDLE_LOW;
               cntNext         = '0;
               bitCntNext      = '0;
               pixCntNext      = '0;
               shiftNext       = '0;
               frameActiveNext = 1'b0;
            end else begin
               cntNext = cntInc;
            end
         end

         IDLE_LOW: begin
            if (dinRise) begin
               stateNext = MEAS_HIGH;
               cntNext   = CNT_W'(1);
            end
         end

         MEAS_HIGH: begin
            if (dinFall) begin
               if (cnt < CNT_MIN_HIGH) begin
                  peNext     = 1'b1;
                  stateNext  = WAIT_RESET;
                  cntNext    = '0;
                  bitCntNext = '0;
                  shiftNext  = '0;
               end else begin
                  shiftNext       = {shiftReg[PIXEL_W-2:0], bitVal};
                  frameActiveNext = 1'b1;
                  stateNext       = MEAS_LOW;
                  cntNext         = CNT_W'(1);
                  // The 24th bit closes the word; the strobe lands one cycle later.
                  if (bitCnt == 5'd23) begin
                     pvNext     = 1'b1;
                     dataNext   = shiftNext;
                     idxNext    = pixCnt;
                     pixCntNext = pixCnt + 16'd1;
                     bitCntNext = '0;
                  end else begin
                     bitCntNext = bitCnt + 5'd1;
                  end
               end
            end else if (cntInc > CNT_MAX_HIGH) begin
               peNext     = 1'b1;
               stateNext  = WAIT_RESET;
               cntNext    = '0;
               bitCntNext = '0;
               shiftNext  = '0;
            end else begin
               cntNext = cntInc;
            end
         end

         MEAS_LOW: begin
            if (dinRise) begin
               stateNext = MEAS_HIGH;
               cntNext   = CNT_W'(1);
            end else if (cntInc >= CNT_RESET) begin
               fdNext          = frameActive;
               stateNext       = IDLE_LOW;
               cntNext         = '0;
               bitCntNext      = '0;
               pixCntNext      = '0;
               shiftNext       = '0;
               frameActiveNext = 1'b0;
            end else begin
               cntNext = cntInc;
            end
         end

         default: begin
            stateNext = WAIT_RESET;
            cntNext   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WAIT_RESET;
         cnt         <= '0;
         bitCnt      <= '0;
         shiftReg    <= '0;
         pixCnt      <= '0;
         frameActive <= 1'b0;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         pulse_err   <= 1'b0;
         pixel_data  <= '0;
         pixel_index <= '0;
      end else begin
         state       <= stateNext;
         cnt         <= cntNext;
         bitCnt      <= bitCntNext;
         shiftReg    <= shiftNext;
         pixCnt      <= pixCntNext;
         frameActive <= frameActiveNext;
         pixel_valid <= pvNext;
         frame_done  <= fdNext;
         pulse_err   <= peNext;
         pixel_data  <= dataNext;
         pixel_index <= idxNext;
      end
   end

`ifdef WS2812B_RX_PASSTHRU_EN
   // Once this node has taken its own pixel, the rest of the frame is forwarded.
   logic passEn;

   always_ff @(posedge clk) begin
      if (reset) begin
         passEn <= 1'b0;
      end else if (stateNext == WAIT_RESET || stateNext == IDLE_LOW) begin
         passEn <= 1'b0;
      end else if (pvNext) begin
         passEn <= 1'b1;
      end
   end

   assign DOUT = passEn & dinS & (state != WAIT_RESET);
`else
   assign DOUT = 1'b0;
`endif

endmodule
